sq_exec_dispatch: RTL
=====================

// Module: sq_exec_dispatch
// PURPOSE
//  Upstream sequencer for the MCU multi-cycle shift unit (sq_shift).
//  - Accepts one shift request via valid/ready, launches the shifter with a single-cycle enable,
//    waits for its done pulse, then holds the result on a valid/ready response port.
//  - Sits between the decode/issue stage and sq_shift; one operation in flight.
// PARAMETERS
//  OP_SZ        32  operand/result width; shift amount width SH_W = $clog2(OP_SZ)
//  TIMEOUT_CYC  64  cycles in WAIT before abort; used only when EXEC_TIMEOUT_EN is defined
// PORTS
//  clk             in   1      single clock, all logic on posedge
//  reset           in   1      synchronous, active-high
//  in_valid        in   1      request valid
//  in_ready        out  1      request accepted when in_valid & in_ready
//  in_op           in   4      opcode: 9 = SHL, 10 = SHR, 11 = SRA; any other value is illegal
//  in_data         in   OP_SZ  operand
//  in_shamt        in   SH_W   shift amount
//  res_valid       out  1      result valid; held until res_ready
//  res_ready       in   1      response consumed when res_valid & res_ready
//  res_data        out  OP_SZ  result
//  res_err         out  1      1 = illegal opcode or timeout
//  busy            out  1      high in any state other than IDLE
//  sh_en           out  1      to shifter enable
//  sh_op           out  4      to shifter op; registered copy of in_op
//  sh_data         out  OP_SZ  to shifter data; registered copy of in_data
//  sh_shift_value  out  SH_W   to shifter shift_value; registered copy of in_shamt
//  sh_out          in   OP_SZ  from shifter result
//  sh_op_done      in   1      from shifter; 1-cycle done pulse
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; res_valid=0, res_err=0, res_data=0, sh_en=0, sh_op=0,
//    sh_data=0, sh_shift_value=0, busy=0.
//  - Reset mid-operation aborts everything. The shifter shares the same reset, so no drain is needed.
//  - State machine (2-bit encoding):
//    - IDLE: in_ready=1. On accept, latch op/data/shamt into the sh_* registers.
//      - Legal op: go to ISSUE.
//      - Illegal op: res_data=0, res_err=1, go to RESP. The shifter is never enabled.
//    - ISSUE: sh_en=1 for exactly one cycle, then WAIT.
//    - WAIT: on sh_op_done, capture res_data=sh_out, set res_err=0, go to RESP. Other shifter outputs are ignored.
//    - RESP: res_valid=1. On res_ready, go to IDLE. res_data and res_err stay stable while stalled.
//  - in_ready is 0 outside IDLE; the sh_* registers stay stable from accept until leaving WAIT.
//  - Latency, legal op with shamt N, accept in cycle 0:
//    - sh_en asserted in cycle 1; sh_op_done expected in cycle 2+N; res_valid from cycle 3+N.
//    - N=0 is legal: done in cycle 2, res_valid in cycle 3.
//  - Illegal op: res_valid in cycle 1.
//  - Re-issue spacing: sh_en is never asserted within 2 cycles after sh_op_done. This guarantees
//    the shifter has returned to its fetch state before the next enable.
//  - sh_op_done outside WAIT is ignored (no capture, no state change).
//  - Accept and response are never in the same cycle; throughput is at most 1 operation per N+4 cycles.
// CONFIGURATION
//  EXEC_TIMEOUT_EN defined:
//    - WAIT counter cleared on entry and incremented each cycle.
//    - When the count reaches TIMEOUT_CYC without sh_op_done: res_data=0, res_err=1, go to RESP.
//    - If sh_op_done and expiry occur in the same cycle, done wins (no error).
//    - A late sh_op_done after abort is ignored.
//  EXEC_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; res_err is set only for illegal ops.
// STRUCTURE
//  - Package mcu_exec_pkg:
//    - opcode constants OP_SHL=4'd9, OP_SHR=4'd10, OP_SRA=4'd11;
//    - state localparams IDLE/ISSUE/WAIT/RESP;
//    - is_shift_op() function.
//  - One state register plus one combinational next-state block.
//  - Optional sub-module exec_watchdog: counter with clear and expiry; instantiated only under EXEC_TIMEOUT_EN.
// TESTING (bench instantiates the real sq_shift, OP_SZ=32)
//  1. SHL: in_op=9, data=32'h0000_0001, shamt=3, res_ready=1
//     -> sh_en in cycle 1; res_valid in cycle 6; res_data=32'h0000_0008; res_err=0.
//  2. SHR with stall: in_op=10, data=32'h8000_0000, shamt=31, res_ready=0 for 5 cycles
//     -> res_data=32'h0000_0001 held stable; in_ready=0 until the handshake completes.
//  3. Illegal op: in_op=4'd3
//     -> res_valid in cycle 1; res_err=1; res_data=0; sh_en never asserted.
//  4. shamt=0: op 9, data=32'hDEAD_BEEF -> res_data=32'hDEAD_BEEF in cycle 3.
//  5. Back-to-back: two legal requests with in_valid held high
//     -> both results correct; checker confirms at least 2 idle cycles between sh_op_done and the next sh_en.
//  6. Reset in WAIT
//     -> next cycle: IDLE, all outputs at reset values. With EXEC_TIMEOUT_EN and a stub shifter
//        that never sends done: res_err=1 in cycle 1+64+1.

Source files
------------

// File: rtl/mcu_exec_pkg.sv
// Shared opcodes, sequencer states and opcode legality check for the shift-unit sequencer.
package mcu_exec_pkg;

    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } exec_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/exec_watchdog.sv
// WAIT-state watchdog: counts cycles while not cleared and flags expiry on the LIMIT-th cycle.
module exec_watchdog #(
    parameter int unsigned LIMIT = 64,
    parameter int unsigned CW    = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    logic [CW-1:0] cnt_q;

    // cnt_q counts completed cycles, so the current cycle is number cnt_q + 1
    assign expired = (32'(cnt_q) == LIMIT - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sq_exec_dispatch.sv
// Sequencer in front of the multi-cycle shifter: accept, enable, wait for done, respond.
// Define EXEC_TIMEOUT_EN to abort WAIT with an error after TIMEOUT_CYC cycles.
module sq_exec_dispatch
    import mcu_exec_pkg::*;
#(
    parameter int unsigned OP_SZ       = 32,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned SH_W        = $clog2(OP_SZ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [OP_SZ-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OP_SZ-1:0] res_data,
    output logic             res_err,
    output logic             busy,
    output logic             sh_en,
    output logic [3:0]       sh_op,
    output logic [OP_SZ-1:0] sh_data,
    output logic [SH_W-1:0]  sh_shift_value,
    input  logic [OP_SZ-1:0] sh_out,
    input  logic             sh_op_done
);

    exec_state_t      state_q, state_d;
    logic [3:0]       sh_op_q, sh_op_d;
    logic [OP_SZ-1:0] sh_data_q, sh_data_d;
    logic [SH_W-1:0]  sh_shamt_q, sh_shamt_d;
    logic [OP_SZ-1:0] res_data_q, res_data_d;
    logic             res_err_q, res_err_d;
    logic             wd_expired;

`ifdef EXEC_TIMEOUT_EN
    exec_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != WAIT),
        .expired (wd_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign wd_expired     = 1'b0;
`endif

    assign in_ready       = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign sh_en          = (state_q == ISSUE);
    assign res_valid      = (state_q == RESP);
    assign sh_op          = sh_op_q;
    assign sh_data        = sh_data_q;
    assign sh_shift_value = sh_shamt_q;
    assign res_data       = res_data_q;
    assign res_err        = res_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sh_op_q    <= '0;
            sh_data_q  <= '0;
            sh_shamt_q <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_op_q    <= sh_op_d;
            sh_data_q  <= sh_data_d;
            sh_shamt_q <= sh_shamt_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_op_d    = sh_op_q;
        sh_data_d  = sh_data_q;
        sh_shamt_d = sh_shamt_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_op_d    = in_op;
                    sh_data_d  = in_data;
                    sh_shamt_d = in_shamt;
                    if (is_shift_op(in_op)) begin
                        state_d = ISSUE;
                    end else begin
                        res_data_d = '0;
                        res_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // done has priority over a simultaneous watchdog expiry
                if (sh_op_done) begin
                    res_data_d = sh_out;
                    res_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (wd_expired) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
